// File: rtl/mem_access_stage.sv
// mem_access_stage
// Memory-access stage behind the 64-bit ALU. It accepts one request at a time
// and performs a doubleword load or store against an internal data memory.
// The access takes LATENCY cycles. The result is then presented to write-back
// through a valid/ready handshake.
//
// Ports:
//   Clk, ResetN                 clock (rising edge), async active-low reset
//   InValid / InReady           request handshake from execute
//   Address, ZeroIn, WriteData  ALU result / byte address, Zero flag, store data
//   MemRead, MemWrite           load / store request
//   OutValid / OutReady         response handshake to write-back
//   ReadData                    loaded doubleword (0 for non-loads and errors)
//   AluResult, ZeroOut          registered copies of Address / ZeroIn
//   Error                       misaligned memory op, or MemRead & MemWrite
//   Busy                        a request is in flight or being presented
module mem_access_stage #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic        InValid,
  output logic        InReady,
  input  logic [63:0] Address,
  input  logic        ZeroIn,
  input  logic [63:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [63:0] ReadData,
  output logic [63:0] AluResult,
  output logic        ZeroOut,
  output logic        Error,
  output logic        Busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [63:0] reqAddr, reqData;
  logic        reqZero, reqRd, reqWr;

  // 2-state storage: starts at zero in simulation and is never reset.
  bit [63:0] mem [0:(1<<DEPTH_LOG2)-1];

  logic                  accept, memOp, badReq, commit;
  logic [DEPTH_LOG2-1:0] reqIdx;

  // InReady depends combinationally on OutReady. This lets a new request be
  // accepted on the same edge that the held response is consumed.
  assign InReady  = (state == IDLE) | ((state == RESP) & OutReady);
  assign OutValid = (state == RESP);
  assign Busy     = (state != IDLE);

  assign accept = InValid & InReady;
  assign memOp  = MemRead | MemWrite;
  assign badReq = (MemRead & MemWrite) | (memOp & (Address[2:0] != 3'b000));
  // The access happens on the last WAIT edge. Store commit and load sample
  // both occur on this edge.
  assign commit = (state == WAIT) && (cnt == 4'd1);
  // Upper address bits are dropped, so addresses wrap around the memory size.
  assign reqIdx = reqAddr[DEPTH_LOG2+2:3];

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      reqAddr   <= '0;
      reqData   <= '0;
      reqZero   <= 1'b0;
      reqRd     <= 1'b0;
      reqWr     <= 1'b0;
      ReadData  <= '0;
      AluResult <= '0;
      ZeroOut   <= 1'b0;
      Error     <= 1'b0;
    end else if (accept) begin
      reqAddr <= Address;
      reqData <= WriteData;
      reqZero <= ZeroIn;
      reqRd   <= MemRead;
      reqWr   <= MemWrite;
      if (badReq || !memOp) begin
        // Error and non-memory requests skip the memory entirely.
        state     <= RESP;
        ReadData  <= '0;
        AluResult <= Address;
        ZeroOut   <= ZeroIn;
        Error     <= badReq;
      end else begin
        state <= WAIT;
        cnt   <= 4'(LATENCY);
      end
    end else if (commit) begin
      state     <= RESP;
      ReadData  <= reqRd ? 64'(mem[reqIdx]) : 64'd0;
      AluResult <= reqAddr;
      ZeroOut   <= reqZero;
      Error     <= 1'b0;
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
    end else if ((state == RESP) && OutReady) begin
      state <= IDLE;
    end
  end

  // A reset before the commit edge forces the state to IDLE, so the commit
  // never fires and the pending store is dropped.
  always_ff @(posedge Clk) begin
    if (commit && reqWr) mem[reqIdx] <= reqData;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage. It holds a transaction-level model: a pending
// response with the cycle it becomes visible, plus a model memory. A compare
// process checks every DUT output against the model at each falling edge.
// Directed scenarios also pin key results with literal values.
module tb_mem_access_stage;
  localparam int LAT = 2;

  logic        Clk = 1'b0, ResetN = 1'b0;
  logic        InValid = 1'b0, InReady;
  logic [63:0] Address = '0, WriteData = '0;
  logic        ZeroIn = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
  logic        OutValid, OutReady = 1'b1;
  logic [63:0] ReadData, AluResult;
  logic        ZeroOut, Error, Busy;

  mem_access_stage #(.DEPTH_LOG2(8), .LATENCY(LAT)) dut (
    .Clk(Clk), .ResetN(ResetN), .InValid(InValid), .InReady(InReady),
    .Address(Address), .ZeroIn(ZeroIn), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .OutValid(OutValid),
    .OutReady(OutReady), .ReadData(ReadData), .AluResult(AluResult),
    .ZeroOut(ZeroOut), .Error(Error), .Busy(Busy));

  always #5 Clk = ~Clk;

  int nChk = 0, nFail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  bit [63:0] mmem [256];
  int        cyc = 0;
  bit        pend = 0, pIsLoad = 0;
  int        pRdy = 0, pIdx = 0;
  bit [63:0] pAddr = 0, pData = 0;
  bit        pZero = 0;
  bit [63:0] eRd = 0, eAlu = 0;
  bit        eZero = 0, eErr = 0;

  function automatic bit mValid();
    return pend && (pRdy <= cyc);
  endfunction

  function automatic bit mInReady();
    return !pend || (mValid() && OutReady);
  endfunction

  always @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      pend = 0; eRd = 0; eAlu = 0; eZero = 0; eErr = 0;
    end else begin
      bit vld, acc, memop, bad;
      vld = mValid();
      acc = InValid && mInReady();
      cyc = cyc + 1;
      if (vld && OutReady) pend = 0;
      if (pend && !vld && pRdy == cyc) begin
        if (pIsLoad) eRd = mmem[pIdx];
        else begin mmem[pIdx] = pData; eRd = 0; end
        eAlu = pAddr; eZero = pZero; eErr = 0;
      end
      if (acc) begin
        memop = MemRead || MemWrite;
        bad   = (MemRead && MemWrite) || (memop && (Address % 8 != 0));
        pend  = 1;
        if (bad || !memop) begin
          pRdy = cyc; eRd = 0; eAlu = Address; eZero = ZeroIn; eErr = bad;
        end else begin
          pRdy = cyc + LAT; pIsLoad = MemRead; pAddr = Address; pZero = ZeroIn;
          pData = WriteData; pIdx = int'((Address / 8) % 256);
        end
      end
    end
  end

  always @(negedge Clk) begin
    chk("OutValid", 64'(OutValid), 64'(mValid()));
    chk("InReady", 64'(InReady), 64'(mInReady()));
    chk("Busy", 64'(Busy), 64'(pend));
    chk("ReadData", ReadData, eRd);
    chk("AluResult", AluResult, eAlu);
    chk("ZeroOut", 64'(ZeroOut), 64'(eZero));
    chk("Error", 64'(Error), 64'(eErr));
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [63:0] a, input logic z, input logic [63:0] wd,
                       input logic rd, input logic wr);
    InValid = 1; Address = a; ZeroIn = z; WriteData = wd; MemRead = rd; MemWrite = wr;
    for (int i = 0; ; i++) begin
      @(negedge Clk);
      if (mInReady()) break;
      if (i > 50) begin
        nChk++; nFail++;
        $display("FAIL issue_timeout: InReady never high, addr %h", a);
        break;
      end
    end
    @(posedge Clk); #1;
    InValid = 0; MemRead = 0; MemWrite = 0;
  endtask

  task automatic waitResp(output int n);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      n++;
      if (OutValid === 1'b1) return;
    end
    nChk++; nFail++;
    $display("FAIL resp_timeout: OutValid never high");
  endtask

  initial begin
    int n;
    // reset state
    repeat (3) @(negedge Clk);
    chk("rst_OutValid", 64'(OutValid), 64'd0);
    chk("rst_InReady", 64'(InReady), 64'd1);
    chk("rst_ReadData", ReadData, 64'd0);
    chk("rst_Busy", 64'(Busy), 64'd0);
    @(posedge Clk); #1 ResetN = 1;

    // non-memory op
    issue(64'h1234, 1, 0, 0, 0); waitResp(n);
    chk("nm_lat", 64'(n), 64'd1);
    chk("nm_alu", AluResult, 64'h1234);
    chk("nm_zero", 64'(ZeroOut), 64'd1);
    chk("nm_rd", ReadData, 64'd0);
    chk("nm_err", 64'(Error), 64'd0);

    // store then load
    issue(64'h40, 0, 64'hDEADBEEFCAFEF00D, 0, 1); waitResp(n);
    chk("st_lat", 64'(n), 64'(LAT + 1));
    chk("st_rd", ReadData, 64'd0);
    issue(64'h40, 0, 0, 1, 0); waitResp(n);
    chk("ld_lat", 64'(n), 64'(LAT + 1));
    chk("ld_rd", ReadData, 64'hDEADBEEFCAFEF00D);

    // wrap-around
    issue(64'h808, 0, 64'hA5, 0, 1); waitResp(n);
    issue(64'h8, 0, 0, 1, 0); waitResp(n);
    chk("wrap_rd", ReadData, 64'hA5);

    // error cases
    issue(64'h43, 0, 0, 1, 0); waitResp(n);
    chk("mis_lat", 64'(n), 64'd1);
    chk("mis_err", 64'(Error), 64'd1);
    chk("mis_rd", ReadData, 64'd0);
    issue(64'h40, 0, 64'h1111, 1, 1); waitResp(n);
    chk("rw_err", 64'(Error), 64'd1);
    issue(64'h40, 0, 0, 1, 0); waitResp(n);
    chk("rw_unchanged", ReadData, 64'hDEADBEEFCAFEF00D);
    chk("rw_err_clr", 64'(Error), 64'd0);

    // backpressure then back-to-back acceptance
    @(posedge Clk); #1 OutReady = 0;
    issue(64'h55, 0, 0, 0, 0); waitResp(n);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("bp_inready", 64'(InReady), 64'd0);
      chk("bp_valid", 64'(OutValid), 64'd1);
      chk("bp_alu", AluResult, 64'h55);
    end
    @(posedge Clk); #1 OutReady = 1;
    issue(64'h66, 1, 0, 0, 0);
    @(negedge Clk);
    chk("b2b_valid", 64'(OutValid), 64'd1);
    chk("b2b_alu", AluResult, 64'h66);

    // reset during a store
    @(posedge Clk); #1;
    issue(64'h80, 0, 64'h77, 0, 1);
    @(posedge Clk); #1 ResetN = 0;
    #1;
    chk("mrst_valid", 64'(OutValid), 64'd0);
    chk("mrst_busy", 64'(Busy), 64'd0);
    chk("mrst_inready", 64'(InReady), 64'd1);
    repeat (2) @(posedge Clk);
    #1 ResetN = 1;
    issue(64'h80, 0, 0, 1, 0); waitResp(n);
    chk("mrst_ld", ReadData, 64'd0);

    repeat (3) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
